// File: rtl/d16_regfile_pkg.sv
// d16_regfile_pkg: state encoding and default geometry shared by the d16 register file.
package d16_regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;
  localparam int NR_DEF = 2;

  // Value each q lane holds during reset and while the clear sweep runs.
  localparam logic Q_RST_BIT = 1'b0;

endpackage

// File: rtl/d16_regfile_rport.sv
// d16_regfile_rport: one registered read port, forced to zero until the file is ready.
// Write-through forwarding is built only when D16_REGFILE_BYPASS_EN is defined.
module d16_regfile_rport
  import d16_regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          run,
  input  logic [AW-1:0] addr_r,
  input  logic [DW-1:0] rd_data,
  input  logic [AW-1:0] addr_w,
  input  logic          w,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_nxt;

`ifdef D16_REGFILE_BYPASS_EN
  always_comb begin
    q_nxt = rd_data;
    if (w && (addr_w == addr_r)) begin
      q_nxt = data;
    end
  end
`else
  // Without forwarding the write-side inputs are intentionally left unused.
  logic unused_wr;
  assign unused_wr = ^{w, addr_w, data};
  assign q_nxt     = rd_data;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !run) begin
      q <= {DW{Q_RST_BIT}};
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/d16_regfile.sv
// d16_regfile: 2**AW x DW register file, NR read ports, one write port, clear-on-reset sweep.
// Optional same-edge write-to-read forwarding: define D16_REGFILE_BYPASS_EN.
module d16_regfile
  import d16_regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NR*AW-1:0] addr_r,
  output logic [NR*DW-1:0] q,
  input  logic [AW-1:0]    addr_w,
  input  logic             w,
  input  logic [DW-1:0]    data,
  output logic             ready,
  output logic             w_err
);

  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + AW'(1);
      if (clr_cnt == LAST) begin
        state_nxt = RUN;
      end
    end
  end

  // The clear sweep owns the write port; nothing is written in a reset cycle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_w;
    mem_wd = data;
    if (!sys_rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end else begin
        mem_we = w;
      end
    end
  end

  assign ready = (state == RUN);

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      w_err <= 1'b0;
    end else if ((state == CLEAR) && w) begin
      w_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rport
    logic [AW-1:0] ra;
    assign ra = addr_r[k*AW +: AW];

    d16_regfile_rport #(
      .DW(DW),
      .AW(AW)
    ) u_rport (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .run     (ready),
      .addr_r  (ra),
      .rd_data (mem[ra]),
      .addr_w  (addr_w),
      .w       (w),
      .data    (data),
      .q       (q[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_d16_regfile.sv
// tb_d16_regfile: randomized self-checking bench for d16_regfile (default and wide builds).
module tb_d16_regfile;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic             sys_rst;
  logic [NR*AW-1:0] addr_r;
  logic [NR*DW-1:0] q;
  logic [AW-1:0]    addr_w;
  logic             w;
  logic [DW-1:0]    data;
  logic             ready;
  logic             w_err;

  d16_regfile #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .addr_r  (addr_r),
    .q       (q),
    .addr_w  (addr_w),
    .w       (w),
    .data    (data),
    .ready   (ready),
    .w_err   (w_err)
  );

  logic         rst_x;
  logic [19:0]  addr_r_x;
  logic [127:0] q_x;
  logic [4:0]   addr_w_x;
  logic         w_x;
  logic [31:0]  data_x;
  logic         ready_x;
  logic         w_err_x;

  d16_regfile #(.DW(32), .AW(5), .NR(4)) dut_x (
    .sys_clk (sys_clk),
    .sys_rst (rst_x),
    .addr_r  (addr_r_x),
    .q       (q_x),
    .addr_w  (addr_w_x),
    .w       (w_x),
    .data    (data_x),
    .ready   (ready_x),
    .w_err   (w_err_x)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the file is a plain array; the sweep is just a count of edges left.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q [NR];
  int            m_left = DEPTH;
  bit            m_ready = 1'b0;
  bit            m_werr = 1'b0;
  bit            bypass;

  function automatic void model_edge();
    int ra;
    if (sys_rst) begin
      m_ready = 1'b0;
      m_werr  = 1'b0;
      m_left  = DEPTH;
      foreach (m_q[k]) m_q[k] = '0;
    end else if (!m_ready) begin
      if (w) m_werr = 1'b1;
      foreach (m_q[k]) m_q[k] = '0;
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      for (int k = 0; k < NR; k++) begin
        ra = int'(addr_r[k*AW +: AW]);
        m_q[k] = (bypass && w && (int'(addr_w) == ra)) ? data : m_mem[ra];
      end
      if (w) m_mem[addr_w] = data;
    end
  endfunction

  function automatic logic [NR*DW+1:0] exp_vec();
    return {m_ready, m_werr, m_q[1], m_q[0]};
  endfunction

  task automatic step(input bit r, input bit wv, input int aw, input int d,
                      input int a0, input int a1);
    sys_rst = r;
    w       = wv;
    addr_w  = aw[AW-1:0];
    data    = d[DW-1:0];
    addr_r  = {a1[AW-1:0], a0[AW-1:0]};
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({ready, w_err, q} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", {ready, w_err, q});
    end
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 0, 0, $urandom, $urandom);
      n_cmp++;
      if (ready !== (i == DEPTH)) begin
        n_err++;
        $display("FAIL clear_ready edge %0d: got %b expected %b", i, ready, (i == DEPTH));
      end
      n_cmp++;
      if (q !== '0) begin
        n_err++;
        $display("FAIL clear_q edge %0d: got %h expected 0", i, q);
      end
    end
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, i, i, $urandom, $urandom);
      n_cmp++;
      if ({ready, w_err, q} !== exp_vec()) begin
        n_err++;
        $display("FAIL fill %0d: got %h expected %h", i, {ready, w_err, q}, exp_vec());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, i, DEPTH - 1 - i);
      n_cmp++;
      if (q !== {16'(DEPTH - 1 - i), 16'(i)}) begin
        n_err++;
        $display("FAIL read %0d: got %h expected %h", i, q, {16'(DEPTH - 1 - i), 16'(i)});
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] first;
    first = bypass ? 16'hBEEF : 16'h0005;
    step(0, 1, 5, 16'hBEEF, 5, 0);
    n_cmp++;
    if (q[DW-1:0] !== first) begin
      n_err++;
      $display("FAIL same_cycle_q0: got %h expected %h", q[DW-1:0], first);
    end
    step(0, 0, 0, 0, 5, 5);
    n_cmp++;
    if (q !== {16'hBEEF, 16'hBEEF}) begin
      n_err++;
      $display("FAIL after_write_q: got %h expected beefbeef", q);
    end
  endtask

  task automatic test_clear_write();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 3, 3);
    step(0, 1, 3, 16'h1234, 3, 3);
    for (int i = 4; i <= DEPTH; i++) begin
      n_cmp++;
      if ({ready, w_err, q} !== {(i - 1 == DEPTH), 1'b1, 32'h0}) begin
        n_err++;
        $display("FAIL clear_werr edge %0d: got %h expected werr=1 q=0", i - 1, {ready, w_err, q});
      end
      step(0, 0, 0, 0, 3, 3);
    end
    n_cmp++;
    if ({ready, w_err} !== 2'b11) begin
      n_err++;
      $display("FAIL werr_ready: got %b expected 11", {ready, w_err});
    end
    step(0, 0, 0, 0, 3, 3);
    n_cmp++;
    if ({w_err, q} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL dropped_write: got %h expected werr=1 q=0", {w_err, q});
    end
  endtask

  task automatic test_reset_midsweep();
    for (int i = 0; i < DEPTH; i++) step(0, 1, i, 16'hFFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (ready !== (i == DEPTH)) begin
        n_err++;
        $display("FAIL resweep_ready edge %0d: got %b expected %b", i, ready, (i == DEPTH));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, i, DEPTH - 1 - i);
      n_cmp++;
      if (q !== '0) begin
        n_err++;
        $display("FAIL resweep_read %0d: got %h expected 0", i, q);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), $urandom_range(0, 1), $urandom, $urandom,
           $urandom, $urandom);
      n_cmp++;
      if ({ready, w_err, q} !== exp_vec()) begin
        n_err++;
        $display("FAIL random %0d: got %h expected %h", i, {ready, w_err, q}, exp_vec());
      end
    end
  endtask

  task automatic test_wide();
    rst_x = 1'b1;
    @(posedge sys_clk); #1;
    rst_x = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge sys_clk); #1;
      n_cmp++;
      if ({ready_x, w_err_x, q_x} !== {(i == 32), 1'b0, 128'h0}) begin
        n_err++;
        $display("FAIL wide_clear edge %0d: got ready=%b werr=%b q=%h", i, ready_x, w_err_x, q_x);
      end
    end
    w_x = 1'b1; addr_w_x = 5'd31; data_x = 32'hCAFEF00D;
    @(posedge sys_clk); #1;
    w_x = 1'b0; addr_r_x = {4{5'd31}};
    @(posedge sys_clk); #1;
    n_cmp++;
    if (q_x !== {4{32'hCAFEF00D}}) begin
      n_err++;
      $display("FAIL wide_read: got %h expected 4x cafef00d", q_x);
    end
  endtask

  initial begin
`ifdef D16_REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_q[k]) m_q[k] = '0;
    rst_x = 1'b1; w_x = 1'b0; addr_w_x = '0; data_x = '0; addr_r_x = '0;
    sys_rst = 1'b1; w = 1'b0; addr_w = '0; data = '0; addr_r = '0;
    @(negedge sys_clk);
    test_reset();
    test_fill_read();
    test_same_cycle();
    test_clear_write();
    test_reset_midsweep();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
